// File: rtl/clk_div_sel.sv
// clk_div_sel: selectable clock divider with boundary-synchronous divisor switching and run/halt/step control.
module clk_div_sel #(
    parameter int CNT_W = 32,
    parameter int DIV0  = 1_000_000,
    parameter int DIV1  = 10_000_000,
    parameter int DIV2  = 1_000_000,
    parameter int DIV3  = 100_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] sel,
    input  logic       run,
    input  logic       step,
    output logic       clk_out,
    output logic       tick,
    output logic [1:0] sel_active,
    output logic       halted
);
    typedef enum logic [1:0] {HALT, RUN, STEP} state_t;
    // Terminal counts: low phase is ceil(D/2) cycles, high phase floor(D/2).
    localparam logic [CNT_W-1:0] LO0 = CNT_W'((DIV0 + 1) / 2 - 1);
    localparam logic [CNT_W-1:0] LO1 = CNT_W'((DIV1 + 1) / 2 - 1);
    localparam logic [CNT_W-1:0] LO2 = CNT_W'((DIV2 + 1) / 2 - 1);
    localparam logic [CNT_W-1:0] LO3 = CNT_W'((DIV3 + 1) / 2 - 1);
    localparam logic [CNT_W-1:0] HI0 = CNT_W'(DIV0 / 2 - 1);
    localparam logic [CNT_W-1:0] HI1 = CNT_W'(DIV1 / 2 - 1);
    localparam logic [CNT_W-1:0] HI2 = CNT_W'(DIV2 / 2 - 1);
    localparam logic [CNT_W-1:0] HI3 = CNT_W'(DIV3 / 2 - 1);
    state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, lo_last, hi_last, last;
    logic phase, phase_n, clk_n, tick_n, step_d, step_rise;
    logic [1:0] sel_n;
    assign step_rise = step & ~step_d;
    assign halted = state == HALT;
    assign lo_last = sel_active == 2'd0 ? LO0 : sel_active == 2'd1 ? LO1 : sel_active == 2'd2 ? LO2 : LO3;
    assign hi_last = sel_active == 2'd0 ? HI0 : sel_active == 2'd1 ? HI1 : sel_active == 2'd2 ? HI2 : HI3;
    assign last = phase ? hi_last : lo_last;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HALT;
            cnt        <= '0;
            phase      <= 1'b0;
            clk_out    <= 1'b0;
            tick       <= 1'b0;
            sel_active <= 2'd0;
            step_d     <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            phase      <= phase_n;
            clk_out    <= clk_n;
            tick       <= tick_n;
            sel_active <= sel_n;
            step_d     <= step;
        end
    end
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        phase_n = phase;
        clk_n   = clk_out;
        tick_n  = 1'b0;
        sel_n   = sel_active;
        case (state)
            HALT: begin
                cnt_n   = '0;
                clk_n   = 1'b0;
                phase_n = 1'b0;
                if (run || step_rise) begin
                    state_n = run ? RUN : STEP;
                    sel_n   = sel;
                end
            end
            default: begin
                cnt_n = cnt == last ? '0 : cnt + CNT_W'(1);
                if (cnt == last) begin
                    phase_n = ~phase;
                    clk_n   = ~phase;
                    tick_n  = ~phase;
                    // Falling edge closes the period: the only safe point to switch divisor or stop.
                    if (phase) begin
                        sel_n = sel;
                        if (state == STEP || !run) state_n = HALT;
                    end
                end
            end
        endcase
    end
endmodule

// File: tb/tb_clk_div_sel.sv
// tb_clk_div_sel: directed checks of clk_div_sel timing, switching, halt/step and async reset.
module tb_clk_div_sel;
    logic clk = 1'b0, rst_n = 1'b0, run = 1'b0, step = 1'b0;
    logic [1:0] sel = 2'd0;
    logic clk_out, tick, halted;
    logic [1:0] sel_active;
    int checks = 0, errors = 0;

    clk_div_sel #(.CNT_W(8), .DIV0(4), .DIV1(6), .DIV2(5), .DIV3(2)) dut (
        .clk(clk), .rst_n(rst_n), .sel(sel), .run(run), .step(step),
        .clk_out(clk_out), .tick(tick), .sel_active(sel_active), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Patterns are read left to right in time: leftmost bit is the first edge.
    task automatic trace(input string tag, input int n, input logic [31:0] ec, input logic [31:0] et);
        for (int i = 0; i < n; i++) begin
            cyc();
            chk($sformatf("%s_clk[%0d]", tag, i), {31'd0, clk_out}, {31'd0, ec[n-1-i]});
            chk($sformatf("%s_tick[%0d]", tag, i), {31'd0, tick}, {31'd0, et[n-1-i]});
        end
    endtask

    initial begin
        cyc();
        cyc();
        chk("rst_clk", {31'd0, clk_out}, 0);
        chk("rst_tick", {31'd0, tick}, 0);
        chk("rst_sel", {30'd0, sel_active}, 0);
        chk("rst_halted", {31'd0, halted}, 1);
        rst_n = 1'b1;
        run = 1'b1;
        trace("c1", 12, 32'b001100110011, 32'b001000100010);
        chk("c1_halted", {31'd0, halted}, 0);
        sel = 2'd2;
        trace("c2a", 10, 32'b0001100011, 32'b0001000010);
        chk("c2a_sel", {30'd0, sel_active}, 2);
        sel = 2'd3;
        trace("c2b", 8, 32'b01010101, 32'b01010101);
        chk("c2b_sel", {30'd0, sel_active}, 3);
        sel = 2'd0;
        trace("c3a", 3, 32'b001, 32'b001);
        sel = 2'd1;
        trace("c3b", 1, 32'b1, 32'b0);
        chk("c3_sel_hold", {30'd0, sel_active}, 0);
        trace("c3c", 7, 32'b0001110, 32'b0001000);
        chk("c3_sel_new", {30'd0, sel_active}, 1);
        trace("c4a", 4, 32'b0011, 32'b0010);
        run = 1'b0;
        trace("c4b", 1, 32'b1, 32'b0);
        chk("c4_not_halted", {31'd0, halted}, 0);
        trace("c4c", 1, 32'b0, 32'b0);
        chk("c4_halted", {31'd0, halted}, 1);
        trace("c4d", 6, 32'b000000, 32'b000000);
        chk("c4_still_halted", {31'd0, halted}, 1);
        sel = 2'd0;
        step = 1'b1;
        trace("c5a", 1, 32'b0, 32'b0);
        chk("c5_stepping", {31'd0, halted}, 0);
        chk("c5_sel", {30'd0, sel_active}, 0);
        trace("c5b", 9, 32'b011000000, 32'b010000000);
        chk("c5_halted", {31'd0, halted}, 1);
        step = 1'b0;
        trace("c5c", 1, 32'b0, 32'b0);
        step = 1'b1;
        trace("c5d", 1, 32'b0, 32'b0);
        chk("c5d_stepping", {31'd0, halted}, 0);
        step = 1'b0;
        trace("c5e", 1, 32'b0, 32'b0);
        step = 1'b1;
        trace("c5f", 7, 32'b1100000, 32'b1000000);
        chk("c5f_halted", {31'd0, halted}, 1);
        step = 1'b0;
        sel = 2'd3;
        run = 1'b1;
        trace("c6a", 2, 32'b01, 32'b01);
        chk("c6_sel", {30'd0, sel_active}, 3);
        rst_n = 1'b0;
        #1;
        chk("c6_async_clk", {31'd0, clk_out}, 0);
        chk("c6_async_tick", {31'd0, tick}, 0);
        chk("c6_async_halted", {31'd0, halted}, 1);
        chk("c6_async_sel", {30'd0, sel_active}, 0);
        sel = 2'd0;
        cyc();
        rst_n = 1'b1;
        trace("c6b", 8, 32'b00110011, 32'b00100010);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/clk_div_sel.md
Name: clk_div_sel

Overview:
- Parametrised successor to the single-counter divider. Produces a slow CPU/display clock from the board clock with four selectable periods.
- Adds glitch-free divisor switching: the select takes effect only at a period boundary. Supports odd divisors with exact period length.
- Adds a run/halt/single-step control for stepping the CPU from a button, and a one-cycle tick enable for logic that stays on clk.

Parameters:
- CNT_W, 32, counter width; must satisfy 2^CNT_W > max(DIVn).
- DIV0, 1_000_000, full output period in clk cycles for sel=0; must be >= 2.
- DIV1, 10_000_000, full period for sel=1; must be >= 2.
- DIV2, 1_000_000, full period for sel=2; must be >= 2.
- DIV3, 100_000, full period for sel=3; must be >= 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- sel  in  2  requested divisor select; any time, sampled only at boundaries
- run  in  1  level; 1 = free-run, 0 = halt after current period
- step  in  1  level from debounced button; rising edge requests one period while halted
- clk_out  out  1  divided clock, registered
- tick  out  1  one-clk-cycle pulse, coincident with each clk_out rise
- sel_active  out  2  divisor select currently in use
- halted  out  1  1 while in HALT

Behaviour:
- Reset (async, rst_n=0):
  - clk_out=0, tick=0, sel_active=0, halted=1.
  - cnt=0, phase=LOW, state=HALT, step_d=0.
- Phase lengths for the selected divisor D:
  - L = ceil(D/2) cycles low, H = floor(D/2) cycles high.
  - Period is exactly D cycles. D=2 gives clk/2. D=5 gives 3 low and 2 high.
- step_d <= step every cycle. step_rise = step & ~step_d.
- States: HALT, RUN, STEP.
- HALT:
  - clk_out=0, cnt held 0, halted=1.
  - At an edge with run=1: go to RUN. If run=0 and step_rise=1: go to STEP.
  - On either transition: sel_active<=sel, cnt<=0, phase=LOW, halted<=0.
- RUN/STEP counting, one increment per clk edge:
  - LOW phase: when cnt==L-1, cnt<=0, clk_out<=1, tick<=1, phase<=HIGH. Otherwise cnt<=cnt+1.
  - HIGH phase: when cnt==H-1, cnt<=0, clk_out<=0, phase<=LOW; this edge is a period boundary. Otherwise cnt<=cnt+1.
  - tick is 0 on every edge other than the rise edge.
- Period boundary:
  - sel_active<=sel; the new L and H apply from the next edge.
  - RUN with run=0: go to HALT, halted<=1.
  - STEP: always go to HALT, halted<=1.
  - Otherwise continue.
- Latency: clk_out rises L edges after the leaving-HALT edge, and falls H edges after that.
- Boundary cases:
  - sel changing mid-period: no effect until the boundary. No runt or stretched pulse.
  - run dropped mid-period: the current period completes. clk_out always parks low.
  - step_rise while in RUN or STEP: ignored, not queued.
  - run=1 and step_rise together in HALT: run wins.
  - step held high: yields only one period.
  - run reasserted on the boundary edge where RUN sees run=0: stays HALT for that edge, then leaves HALT on the next edge.
  - rst_n asserted mid-period: immediate return to reset values, including clk_out=0 asynchronously.
  - cnt compare uses CNT_W-bit unsigned values. L-1 and H-1 are computed at elaboration from the parameters.

Test Plan (DIV0=4, DIV1=6, DIV2=5, DIV3=2):
1. Release reset, sel=0, run=1 at edge E0 -> clk_out rises after E2 and falls after E4, repeating every 4 cycles; tick high one cycle after E2, E6, E10.
2. sel=2, run=1 -> clk_out low 3 cycles, high 2 cycles, period 5; sel=3 -> clk/2 toggling every edge, tick every 2 cycles.
3. Running sel=0, change sel to 1 one cycle after a rise -> remaining high phase stays 2 cycles; sel_active becomes 1 at the fall; next period is 3 low and 3 high.
4. Running sel=1, run dropped mid-high -> high completes (3 cycles total), clk_out=0, halted=1 at that edge, no further ticks.
5. Halted sel=0, step pulsed 0->1 and held 10 cycles -> exactly one 4-cycle period, one tick, halted=1; a second step during STEP is ignored.
6. rst_n low during a high phase -> clk_out, tick and halted take their reset values immediately, without waiting for a clk edge; after release with run=1, normal timing resumes from case 1.
